// File: rtl/kv_arb_pkg.sv
// Shared types and constants for the K/V Psum arbiter.
package kv_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BURST, S_RELEASE} state_e;

  localparam int NUM_REQ_DEF = 2;
  localparam int BURST_LEN   = 256;
  localparam int SRC_W       = $clog2(NUM_REQ_DEF);
endpackage

// File: rtl/rr_pick.sv
// One-hot winner select from a request vector, searching from last_i+1.
// Build with KV_ARB_FIXED_PRIO_EN for lowest-index-wins (last_i ignored).
module rr_pick #(
  parameter int N  = 2,
  parameter int SW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [SW-1:0] idx_o
);
  int   j;
  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
`ifdef KV_ARB_FIXED_PRIO_EN
    for (int k = 0; k < N; k++) begin
      j = k;
      if (req_i[j] && !found) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = SW'(j);
      end
    end
`else
    for (int k = 1; k <= N; k++) begin
      j = (int'(last_i) + k) % N;
      if (req_i[j] && !found) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = SW'(j);
      end
    end
`endif
  end
endmodule

// File: rtl/psum_kv_arbiter.sv
// Shares one Psum sink between the K and V systolic slaves, one full burst per grant.
// KV_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module psum_kv_arbiter
  import kv_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int BURST_LEN = kv_arb_pkg::BURST_LEN,
  parameter int DATA_W    = 80,
  localparam int SW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      s_clk,
  input  logic                      s_rst,
  input  logic [NUM_REQ-1:0]        i_Req,
  output logic [NUM_REQ-1:0]        o_Grant,
  input  logic [NUM_REQ-1:0]        i_PsumValid,
  input  logic [NUM_REQ*DATA_W-1:0] i_PsumData,
  input  logic                      i_Sink_ready,
  output logic                      o_PsumValid,
  output logic [DATA_W-1:0]         o_PsumData,
  output logic [SW-1:0]             o_PsumSrc,
  output logic                      o_PsumLast,
  output logic                      o_Busy,
  output logic                      o_ProtoErr
);
  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d, pick_gnt;
  logic [SW-1:0]       win_q, win_d, ptr_q, pick_idx;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                vld_q, vld_d, last_q, last_d, err_q, err_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [SW-1:0]       src_q, src_d;
  logic                beat_ok, rogue;

`ifdef KV_ARB_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  logic [SW-1:0] ptr_d;

  always_ff @(posedge s_clk) begin
    if (s_rst) ptr_q <= SW'(NUM_REQ - 1);
    else       ptr_q <= ptr_d;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_RELEASE) ptr_d = win_q;
  end
`endif

  rr_pick #(.N(NUM_REQ), .SW(SW)) u_pick (
    .req_i  (i_Req),
    .last_i (ptr_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  // grant_q is one-hot on the winner only in S_BURST, so any other valid is a violation
  assign beat_ok = (state_q == S_BURST) && i_PsumValid[win_q];
  assign rogue   = |(i_PsumValid & ~grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    data_d  = data_q;
    src_d   = src_q;
    err_d   = err_q | rogue;
    case (state_q)
      S_IDLE: begin
        if (|i_Req && i_Sink_ready) begin
          grant_d = pick_gnt;
          win_d   = pick_idx;
          cnt_d   = '0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (beat_ok) begin
          vld_d  = 1'b1;
          data_d = i_PsumData[int'(win_q)*DATA_W +: DATA_W];
          src_d  = win_q;
          last_d = (cnt_q == LAST_BEAT);
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST_BEAT) begin
            grant_d = '0;
            state_d = S_RELEASE;
          end
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      data_q  <= data_d;
      src_q   <= src_d;
      err_q   <= err_d;
    end
  end

  assign o_Grant     = grant_q;
  assign o_PsumValid = vld_q;
  assign o_PsumData  = data_q;
  assign o_PsumSrc   = src_q;
  assign o_PsumLast  = last_q;
  assign o_Busy      = (state_q != S_IDLE);
  assign o_ProtoErr  = err_q;
endmodule

// File: tb/tb_psum_kv_arbiter.sv
// Directed bench for psum_kv_arbiter: bursts, ordering, sink gating, rogue valids, reset.
module tb_psum_kv_arbiter;
  localparam int N  = 2;
  localparam int BL = 256;
  localparam int DW = 80;

  logic            s_clk = 1'b0;
  logic            s_rst;
  logic [N-1:0]    i_Req;
  logic [N-1:0]    o_Grant;
  logic [N-1:0]    i_PsumValid;
  logic [N*DW-1:0] i_PsumData;
  logic            i_Sink_ready;
  logic            o_PsumValid;
  logic [DW-1:0]   o_PsumData;
  logic [0:0]      o_PsumSrc;
  logic            o_PsumLast;
  logic            o_Busy;
  logic            o_ProtoErr;

  int errors = 0;
  int checks = 0;

  psum_kv_arbiter #(.NUM_REQ(N), .BURST_LEN(BL), .DATA_W(DW)) dut (
    .s_clk        (s_clk),
    .s_rst        (s_rst),
    .i_Req        (i_Req),
    .o_Grant      (o_Grant),
    .i_PsumValid  (i_PsumValid),
    .i_PsumData   (i_PsumData),
    .i_Sink_ready (i_Sink_ready),
    .o_PsumValid  (o_PsumValid),
    .o_PsumData   (o_PsumData),
    .o_PsumSrc    (o_PsumSrc),
    .o_PsumLast   (o_PsumLast),
    .o_Busy       (o_Busy),
    .o_ProtoErr   (o_ProtoErr)
  );

  always #5 s_clk = ~s_clk;

  task automatic tick();
    @(posedge s_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_grant"}, DW'(o_Grant), '0);
    chk({p, "_vld"},   DW'(o_PsumValid), '0);
    chk({p, "_data"},  o_PsumData, '0);
    chk({p, "_src"},   DW'(o_PsumSrc), '0);
    chk({p, "_last"},  DW'(o_PsumLast), '0);
    chk({p, "_busy"},  DW'(o_Busy), '0);
    chk({p, "_err"},   DW'(o_ProtoErr), '0);
  endtask

  task automatic do_reset();
    s_rst = 1'b1; i_Req = '0; i_PsumValid = '0;
    tick();
    s_rst = 1'b0;
  endtask

  // Caller has already seen the grant; drives nb beats with data = beat index.
  task automatic burst(input int src, input int nb, input bit rogue, input bit drop_req);
    int nv = 0, nlast = 0, bad_d = 0, bad_s = 0, bad_g = 0, last_at = -1;
    logic [N-1:0] oh;
    oh = '0; oh[src] = 1'b1;
    for (int b = 0; b < nb; b++) begin
      if (o_Grant !== oh) bad_g++;
      i_PsumValid = '0;
      i_PsumValid[src] = 1'b1;
      i_PsumData[src*DW +: DW] = DW'(b);
      if (rogue && b == 10) begin
        i_PsumValid[1-src] = 1'b1;
        i_PsumData[(1-src)*DW +: DW] = DW'(32'hBAD);
      end
      if (drop_req) i_Req = '0;
      tick();
      if (o_PsumValid !== 1'b1) bad_d++;
      else begin
        nv++;
        if (o_PsumData !== DW'(b)) bad_d++;
        if (32'(o_PsumSrc) !== src) bad_s++;
        if (o_PsumLast === 1'b1) begin nlast++; last_at = b; end
      end
    end
    i_PsumValid = '0;
    chk($sformatf("beats_s%0d", src),   DW'(nv), DW'(nb));
    chk($sformatf("data_s%0d", src),    DW'(bad_d), '0);
    chk($sformatf("src_s%0d", src),     DW'(bad_s), '0);
    chk($sformatf("hold_s%0d", src),    DW'(bad_g), '0);
    chk($sformatf("nlast_s%0d", src),   DW'(nlast), DW'((nb == BL) ? 1 : 0));
    chk($sformatf("lastpos_s%0d", src), DW'(last_at), DW'((nb == BL) ? BL-1 : -1));
  endtask

  // Release cycle, idle cycle, then the expected next grant.
  task automatic after_burst(input logic [N-1:0] next_oh);
    chk("rel_grant", DW'(o_Grant), '0);
    chk("rel_busy",  DW'(o_Busy), DW'(1));
    tick();
    chk("idle_grant", DW'(o_Grant), '0);
    chk("idle_busy",  DW'(o_Busy), '0);
    tick();
    chk("next_grant", DW'(o_Grant), DW'(next_oh));
  endtask

  initial begin
    int exp_src, nxt, bad;
    logic [N-1:0] oh;
    s_rst = 1'b1; i_Req = '0; i_PsumValid = '0; i_PsumData = '0; i_Sink_ready = 1'b1;
    tick(); tick();
    chk_rst("rst");
    s_rst = 1'b0;

    // Single request, request dropped during the burst
    i_Req = 2'b01;
    tick();
    chk("single_grant", DW'(o_Grant), DW'(2'b01));
    chk("single_busy",  DW'(o_Busy), DW'(1));
    burst(0, BL, 1'b0, 1'b1);
    after_burst(2'b00);

    // Both requesting from reset: 0,1,0,1 (fixed priority: all 0)
    do_reset();
    i_Req = 2'b11;
    tick();
    chk("sim_grant0", DW'(o_Grant), DW'(2'b01));
    for (int r = 0; r < 4; r++) begin
`ifdef KV_ARB_FIXED_PRIO_EN
      exp_src = 0; nxt = 0;
`else
      exp_src = r % 2; nxt = (r + 1) % 2;
`endif
      burst(exp_src, BL, 1'b0, r == 3);
      oh = '0;
      if (r < 3) oh[nxt] = 1'b1;
      after_burst(oh);
    end
    chk("sim_err", DW'(o_ProtoErr), '0);

    // Sink not ready blocks grant; ready falling mid-burst has no effect
    i_Sink_ready = 1'b0; i_Req = 2'b10; bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (o_Grant !== 2'b00) bad++;
    end
    chk("noready_grant", DW'(bad), '0);
    i_Sink_ready = 1'b1;
    tick();
    chk("ready_grant", DW'(o_Grant), DW'(2'b10));
    i_Sink_ready = 1'b0;
    burst(1, BL, 1'b0, 1'b1);
    after_burst(2'b00);
    i_Sink_ready = 1'b1;

    // Rogue valid from slave 1 during slave 0's burst
    chk("pre_rogue_err", DW'(o_ProtoErr), '0);
    i_Req = 2'b01;
    tick();
    chk("rogue_grant", DW'(o_Grant), DW'(2'b01));
    burst(0, BL, 1'b1, 1'b1);
    chk("rogue_err", DW'(o_ProtoErr), DW'(1));
    after_burst(2'b00);

    // Valid while idle is dropped and flagged
    do_reset();
    chk("idle_err0", DW'(o_ProtoErr), '0);
    i_PsumValid = 2'b10; i_PsumData[DW +: DW] = DW'(32'h55);
    tick();
    i_PsumValid = '0;
    chk("idlevld_fwd", DW'(o_PsumValid), '0);
    chk("idlevld_err", DW'(o_ProtoErr), DW'(1));

    // Reset after beat 100, then a fresh full burst
    do_reset();
    i_Req = 2'b01;
    tick();
    chk("mid_grant", DW'(o_Grant), DW'(2'b01));
    burst(0, 101, 1'b0, 1'b1);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    chk_rst("mrst");
    i_Req = 2'b01;
    tick();
    chk("fresh_grant", DW'(o_Grant), DW'(2'b01));
    burst(0, BL, 1'b0, 1'b1);
    after_burst(2'b00);

    // Request dropped before it could be granted
    i_Sink_ready = 1'b0; i_Req = 2'b01;
    tick(); tick();
    i_Req = '0; i_Sink_ready = 1'b1;
    tick(); tick();
    chk("drop_grant", DW'(o_Grant), '0);
    chk("drop_busy",  DW'(o_Busy), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
